// File: rtl/quad_enc_decoder.sv
// ---------------------------------------------------------------------------
// quad_enc_decoder
//   x4 quadrature decoder for A/B/I encoder signals. Produces a signed
//   position count, the direction of the last counted edge, the clk-cycle
//   period between the last two counted edges, and an index capture.
//
//   Optional build macro: QE_DEC_FILTER_EN
//     defined   - each synchronised A/B/I passes through a FILTER_DEPTH-sample
//                 glitch filter (adds FILTER_DEPTH cycles of latency)
//     undefined - synchronised signals feed the decoder directly
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   QE_dec_enable   1 = decode and count
//   QE_A/QE_B/QE_I  asynchronous encoder inputs
//   clear_count     1-cycle pulse: zero count, clear sticky flags
//   count_value     signed position (wraps, no saturation)
//   direction       1 = forward, 0 = reverse (last counted edge)
//   period_value    clk cycles between the last two counted edges
//   period_valid    period_value is meaningful
//   index_count     count_value captured at the last index rising edge
//   index_seen      sticky index flag
//   count_error     sticky illegal-transition flag
//
// Handshake: there is no valid/ready pair; all outputs are registered state
// that firmware may read at any time.
// ---------------------------------------------------------------------------
module quad_enc_decoder #(
    parameter int COUNT_WIDTH  = 32,
    parameter int PERIOD_WIDTH = 24,
    parameter int FILTER_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    QE_dec_enable,
    input  logic                    QE_A,
    input  logic                    QE_B,
    input  logic                    QE_I,
    input  logic                    clear_count,
    output logic [COUNT_WIDTH-1:0]  count_value,
    output logic                    direction,
    output logic [PERIOD_WIDTH-1:0] period_value,
    output logic                    period_valid,
    output logic [COUNT_WIDTH-1:0]  index_count,
    output logic                    index_seen,
    output logic                    count_error
);

    typedef enum logic [1:0] {
        S_QD_IDLE = 2'd0,
        S_QD_ARM  = 2'd1,
        S_QD_RUN  = 2'd2
    } state_t;

    // Bit order everywhere: [2]=A, [1]=B, [0]=I
    logic [2:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [2:0] dec_in;

    always_comb begin
        sync1_d = {QE_A, QE_B, QE_I};
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

`ifdef QE_DEC_FILTER_EN
    localparam int FCW = $clog2(FILTER_DEPTH + 1);
    logic [2:0]     filt_q, filt_d;
    logic [FCW-1:0] fcnt_q [3];
    logic [FCW-1:0] fcnt_d [3];

    // The counter tracks how many consecutive samples have disagreed with
    // the filter output; the FILTER_DEPTH-th one flips the output.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            filt_d[i] = filt_q[i];
            fcnt_d[i] = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == FCW'(FILTER_DEPTH - 1)) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            filt_q <= '0;
            for (int i = 0; i < 3; i++) fcnt_q[i] <= '0;
        end else begin
            filt_q <= filt_d;
            for (int i = 0; i < 3; i++) fcnt_q[i] <= fcnt_d[i];
        end
    end

    assign dec_in = filt_q;
`else
    assign dec_in = sync2_q;
`endif

    state_t                  state_q, state_d;
    logic [1:0]              prev_ab_q, prev_ab_d;
    logic                    i_prev_q, i_prev_d;
    logic [COUNT_WIDTH-1:0]  count_q, count_d;
    logic                    dir_q, dir_d;
    logic [PERIOD_WIDTH-1:0] timer_q, timer_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic                    pvalid_q, pvalid_d;
    logic                    edge_seen_q, edge_seen_d;
    logic [COUNT_WIDTH-1:0]  idx_cnt_q, idx_cnt_d;
    logic                    idx_seen_q, idx_seen_d;
    logic                    err_q, err_d;

    logic [1:0]              ab_cur;
    logic                    step_fwd, step_rev, step_ill;
    logic                    timer_sat;
    logic [PERIOD_WIDTH-1:0] timer_inc;

    assign ab_cur    = dec_in[2:1];
    assign timer_sat = &timer_q;
    assign timer_inc = timer_sat ? timer_q : timer_q + 1'b1;

    always_comb begin
        step_fwd = 1'b0;
        step_rev = 1'b0;
        case ({prev_ab_q, ab_cur})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_fwd = 1'b1;
            4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: step_rev = 1'b1;
            default: ;
        endcase
        step_ill = (prev_ab_q ^ ab_cur) == 2'b11;
    end

    always_comb begin
        state_d     = state_q;
        prev_ab_d   = prev_ab_q;
        i_prev_d    = dec_in[0];
        count_d     = count_q;
        dir_d       = dir_q;
        timer_d     = timer_q;
        period_d    = period_q;
        pvalid_d    = pvalid_q;
        edge_seen_d = edge_seen_q;
        idx_cnt_d   = idx_cnt_q;
        idx_seen_d  = idx_seen_q;
        err_d       = err_q;

        case (state_q)
            S_QD_IDLE: begin
                timer_d     = '0;
                pvalid_d    = 1'b0;
                edge_seen_d = 1'b0;
                if (QE_dec_enable) state_d = S_QD_ARM;
            end
            S_QD_ARM: begin
                // Seed prev_ab with the current level so enabling never counts.
                prev_ab_d = ab_cur;
                state_d   = S_QD_RUN;
            end
            S_QD_RUN: begin
                if (!QE_dec_enable) begin
                    state_d  = S_QD_IDLE;
                    timer_d  = '0;
                    pvalid_d = 1'b0;
                end else begin
                    prev_ab_d = ab_cur;
                    timer_d   = timer_inc;
                    if (timer_sat) begin
                        // Stalled shaft: the next edge cannot yield a period.
                        pvalid_d    = 1'b0;
                        edge_seen_d = 1'b0;
                    end
                    if (step_ill) err_d = 1'b1;
                    if (step_fwd || step_rev) begin
                        count_d     = step_fwd ? count_q + 1'b1 : count_q - 1'b1;
                        dir_d       = step_fwd;
                        period_d    = timer_inc;
                        timer_d     = '0;
                        pvalid_d    = edge_seen_q && !timer_sat && (dir_q == step_fwd);
                        edge_seen_d = 1'b1;
                    end
                    if (dec_in[0] && !i_prev_q) begin
                        idx_cnt_d  = count_d;
                        idx_seen_d = 1'b1;
                    end
                end
            end
            default: state_d = S_QD_IDLE;
        endcase

        // clear_count discards this cycle's edge/index but prev_ab keeps
        // tracking so the discarded edge is not counted later.
        if (clear_count) begin
            count_d     = '0;
            dir_d       = dir_q;
            period_d    = period_q;
            idx_cnt_d   = idx_cnt_q;
            idx_seen_d  = 1'b0;
            err_d       = 1'b0;
            pvalid_d    = 1'b0;
            edge_seen_d = 1'b0;
            timer_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_QD_IDLE;
            prev_ab_q   <= '0;
            i_prev_q    <= 1'b0;
            count_q     <= '0;
            dir_q       <= 1'b0;
            timer_q     <= '0;
            period_q    <= '0;
            pvalid_q    <= 1'b0;
            edge_seen_q <= 1'b0;
            idx_cnt_q   <= '0;
            idx_seen_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_ab_q   <= prev_ab_d;
            i_prev_q    <= i_prev_d;
            count_q     <= count_d;
            dir_q       <= dir_d;
            timer_q     <= timer_d;
            period_q    <= period_d;
            pvalid_q    <= pvalid_d;
            edge_seen_q <= edge_seen_d;
            idx_cnt_q   <= idx_cnt_d;
            idx_seen_q  <= idx_seen_d;
            err_q       <= err_d;
        end
    end

    assign count_value  = count_q;
    assign direction    = dir_q;
    assign period_value = period_q;
    assign period_valid = pvalid_q;
    assign index_count  = idx_cnt_q;
    assign index_seen   = idx_seen_q;
    assign count_error  = err_q;

endmodule

// File: doc/quad_enc_decoder.md
Name: quad_enc_decoder

Overview:
Decodes A/B/I quadrature signals from a real encoder, or from the on-chip QE generator in loopback, into a signed position count, a direction flag and an edge-to-edge period measurement. It sits between the encoder input pins and the motion register bank. Controller firmware reads position, period and status from it. Counting is x4: every legal A/B edge counts.

Parameters:
COUNT_WIDTH, 32, width of the signed position counter
PERIOD_WIDTH, 24, width of the edge-period timer (clk cycles)
FILTER_DEPTH, 4, number of consecutive identical samples required by the optional glitch filter

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
QE_dec_enable  input  1  1 = decode and count
QE_A  input  1  encoder channel A (asynchronous)
QE_B  input  1  encoder channel B (asynchronous)
QE_I  input  1  encoder index (asynchronous)
clear_count  input  1  1-cycle pulse; zeroes count and clears sticky flags
count_value  output  COUNT_WIDTH  signed position, two's complement
direction  output  1  1 = forward, 0 = reverse (direction of the last counted edge)
period_value  output  PERIOD_WIDTH  clk cycles between the last two counted edges
period_valid  output  1  period_value is meaningful
index_count  output  COUNT_WIDTH  count_value latched at the last index rising edge
index_seen  output  1  sticky: an index rising edge has occurred
count_error  output  1  sticky: an illegal A/B transition occurred (both bits changed)

Behaviour:
- Reset (sampled on posedge clk while reset=1): all outputs 0; FSM to S_QD_IDLE; synchronisers cleared to 0; period timer = 0.
- Inputs: A, B and I each pass through a 2-flop synchroniser. The synchronisers run whenever reset=0, regardless of enable.
- Forward Gray sequence on {A,B}: 00->01->11->10->00, giving +1. The reverse sequence gives -1. No change gives no count.
- Illegal transition (both bits change in one sample): count_error is set; no count; prev_AB is still updated.
- Latency: a pin change to the updated count_value is 3 clk cycles (2 sync stages + 1 register).
- Count arithmetic: count wraps modulo 2^COUNT_WIDTH (0x7FFFFFFF +1 -> 0x80000000; 0 -1 -> 0xFFFFFFFF). There is no saturation.
- FSM states:
  S_QD_IDLE: enable=0. No counting; period timer held at 0; period_valid=0. Goes to S_QD_ARM when enable=1.
  S_QD_ARM: one cycle. Captures the synchronised {A,B} into prev_AB so that no spurious count occurs. Goes to S_QD_RUN.
  S_QD_RUN: decodes each cycle. Goes to S_QD_IDLE when enable=0, taking effect the same cycle; an edge in that cycle is not counted.
- Period timer (S_QD_RUN only):
  - Increments every cycle and saturates at all-ones.
  - On a counted edge: period_value <= timer + 1 (saturating), then timer <= 0.
  - period_valid = 1 only after two consecutive counted edges in the same direction.
  - A direction reversal clears period_valid; the edge that caused it restarts the timer.
  - Timer saturation clears period_valid (stalled shaft).
- Index: on a synchronised I rising edge in S_QD_RUN, index_count <= the count value after this cycle's update, and index_seen <= 1.
- clear_count: the next cycle, count_value=0, index_seen=0, count_error=0, period_valid=0 and timer=0.
  - clear_count wins over a simultaneous edge or index; that edge is discarded.
  - index_count and direction are kept.
- reset mid-operation: takes precedence over everything and returns all state to the reset values above.

Optional Feature:
QE_DEC_FILTER_EN
- Defined: each synchronised A/B/I passes through a filter. The filter output changes only after FILTER_DEPTH consecutive identical samples that differ from the current output. Pulses shorter than FILTER_DEPTH cycles are rejected. Latency grows by FILTER_DEPTH cycles (7 total at default). Filter state resets to 0.
- Undefined: the filter is absent; the synchronised signals feed the decoder directly; latency is 3 cycles.

Test Plan:
- Reset, enable=1, 8 forward Gray steps 20 clk apart -> count_value=8, direction=1, period_value=20, period_valid=1, count_error=0.
- From count=8, 3 reverse steps -> count_value=5, direction=0. period_valid=0 after the first reverse edge and 1 after the second, with period_value=20.
- Preload by reversing from 0 by 1 step -> count_value=0xFFFFFFFF. Then 1 forward step -> 0x00000000 (wrap checked both ways).
- {A,B} 00->11 in one step -> count_error=1 and count unchanged. Then clear_count -> count_error=0 and count_value=0.
- Index pulse while count=5 -> index_count=5, index_seen=1. clear_count coincident with a forward edge -> count_value=0 and index_count still 5.
- QE_DEC_FILTER_EN defined: a 2-clk glitch on A -> no count. A clean step -> count updates exactly 7 cycles after the pin change.
